// File: rtl/mc_control_seq.sv
// Multicycle control sequencer: steps decoded instructions through IF/ID/EXE/MEM/WB,
// with memory wait states and bus-error timeout, divide stall, exceptions, interrupts and ERET.
module mc_control_seq #(
  parameter int ADDR_HIGH_W  = 22,
  parameter int MEM_WAIT_MAX = 15,
  parameter int DIV_CYCLES   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   is_jump,
  input  logic                   is_link,
  input  logic                   is_eret,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic                   is_branch,
  input  logic                   is_div,
  input  logic                   branch_taken,
  input  logic                   ex_reserved,
  input  logic                   ex_syscall,
  input  logic                   ex_break,
  input  logic                   irq,
  input  logic [ADDR_HIGH_W-1:0] addr_high,
  input  logic                   mem_ready,
  output logic [2:0]             Wpc,
  output logic                   Wir,
  output logic                   Waluresult,
  output logic                   mem_req,
  output logic                   io_req,
  output logic                   mem_we,
  output logic                   reg_we,
  output logic                   div_start,
  output logic                   Wepc,
  output logic [4:0]             exc_code,
  output logic [2:0]             state,
  output logic                   busy
);

  localparam int MCW = $clog2(MEM_WAIT_MAX + 1);
  localparam int DCW = $clog2(DIV_CYCLES + 1);
  localparam logic [MCW-1:0] MEM_LAST = MCW'(MEM_WAIT_MAX - 1);
  localparam logic [MCW-1:0] MEM_MAX  = MCW'(MEM_WAIT_MAX);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_CYCLES - 1);

  localparam logic [2:0] PC_HOLD = 3'b000;
  localparam logic [2:0] PC_INC  = 3'b001;
  localparam logic [2:0] PC_JMP  = 3'b010;
  localparam logic [2:0] PC_BR   = 3'b011;
  localparam logic [2:0] PC_VEC  = 3'b100;
  localparam logic [2:0] PC_EPC  = 3'b101;

  localparam logic [4:0] EXC_IRQ  = 5'd0;
  localparam logic [4:0] EXC_BUS  = 5'd7;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BRK  = 5'd9;
  localparam logic [4:0] EXC_RSVD = 5'd10;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_DIVW = 3'd6,
    S_EXC  = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [MCW-1:0]   mem_cnt_q, mem_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [4:0]       exc_code_q, exc_code_d;

  logic io_space;
  logic mem_timeout;
  logic mem_done;

  assign io_space    = &addr_high;
  assign mem_timeout = (mem_cnt_q == MEM_LAST) && !mem_ready;

  // Handshake: mem_req is held high while in MEM until the cycle mem_ready is
  // sampled high (transfer completes that cycle); on timeout it drops instead.
  always_comb begin
    state_d    = state_q;
    mem_cnt_d  = mem_cnt_q;
    div_cnt_d  = div_cnt_q;
    exc_code_d = exc_code_q;
    Wpc        = PC_HOLD;
    Wir        = 1'b0;
    Waluresult = 1'b0;
    mem_req    = 1'b0;
    io_req     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    div_start  = 1'b0;
    Wepc       = 1'b0;
    mem_done   = 1'b0;

    case (state_q)
      S_INIT: state_d = S_IF;

      S_IF: begin
        Wir     = 1'b1;
        Wpc     = PC_INC;
        state_d = S_ID;
      end

      S_ID: begin
        if (ex_reserved || ex_syscall || ex_break) begin
          state_d    = S_EXC;
          exc_code_d = ex_reserved ? EXC_RSVD : (ex_syscall ? EXC_SYS : EXC_BRK);
        end else if (is_eret) begin
          Wpc     = PC_EPC;
          state_d = S_IF;
        end else if (is_jump) begin
          Wpc    = PC_JMP;
          reg_we = is_link;
          if (irq) begin
            state_d    = S_EXC;
            exc_code_d = EXC_IRQ;
          end else begin
            state_d = S_IF;
          end
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        Waluresult = 1'b1;
        if (is_load || is_store) begin
          state_d   = S_MEM;
          mem_cnt_d = '0;
          div_cnt_d = '0;
        end else if (is_branch) begin
          if (branch_taken) Wpc = PC_BR;
          if (irq) begin
            state_d    = S_EXC;
            exc_code_d = EXC_IRQ;
          end else begin
            state_d = S_IF;
          end
        end else if (is_div) begin
          div_start = 1'b1;
          state_d   = S_DIVW;
          mem_cnt_d = '0;
          div_cnt_d = '0;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (io_space) begin
          io_req   = 1'b1;
          mem_we   = is_store;
          mem_done = 1'b1;
        end else begin
          mem_req = !mem_timeout;
          mem_we  = is_store && !mem_timeout;
          if (mem_ready) begin
            mem_done = 1'b1;
          end else begin
            if (mem_cnt_q != MEM_MAX) mem_cnt_d = mem_cnt_q + MCW'(1);
            if (mem_timeout) begin
              state_d    = S_EXC;
              exc_code_d = EXC_BUS;
            end
          end
        end
        if (mem_done) begin
          if (is_load) begin
            state_d = S_WB;
          end else if (irq) begin
            state_d    = S_EXC;
            exc_code_d = EXC_IRQ;
          end else begin
            state_d = S_IF;
          end
        end
      end

      S_DIVW: begin
        if (div_cnt_q == DIV_LAST) state_d = S_WB;
        else                       div_cnt_d = div_cnt_q + DCW'(1);
      end

      S_WB: begin
        reg_we = 1'b1;
        if (irq) begin
          state_d    = S_EXC;
          exc_code_d = EXC_IRQ;
        end else begin
          state_d = S_IF;
        end
      end

      S_EXC: begin
        Wepc    = 1'b1;
        Wpc     = PC_VEC;
        state_d = S_IF;
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      mem_cnt_q  <= '0;
      div_cnt_q  <= '0;
      exc_code_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_cnt_q  <= mem_cnt_d;
      div_cnt_q  <= div_cnt_d;
      exc_code_q <= exc_code_d;
    end
  end

  assign exc_code = exc_code_q;
  assign state    = state_q;
  assign busy     = (state_q != S_IF);

endmodule

// File: tb/tb_mc_control_seq.sv
// Directed bench for mc_control_seq: per-cycle expected outputs go into a queue,
// a negedge monitor pops and compares against the packed DUT outputs.
module tb_mc_control_seq;

  localparam int AW = 22;

  localparam logic [2:0] ST_INIT = 3'd0, ST_IF = 3'd1, ST_ID = 3'd2, ST_EXE = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_DIVW = 3'd6, ST_EXC = 3'd7;

  // strobe byte: {Wir, Waluresult, mem_req, io_req, mem_we, reg_we, div_start, Wepc}
  localparam logic [7:0] S_IR = 8'h80, S_ALU = 8'h40, S_MREQ = 8'h20, S_IOREQ = 8'h10,
                         S_WE = 8'h08, S_RWE = 8'h04, S_DIV = 8'h02, S_EPC = 8'h01;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          is_jump = 0, is_link = 0, is_eret = 0, is_load = 0, is_store = 0;
  logic          is_branch = 0, is_div = 0, branch_taken = 0;
  logic          ex_reserved = 0, ex_syscall = 0, ex_break = 0, irq = 0;
  logic [AW-1:0] addr_high = '0;
  logic          mem_ready = 0;

  logic [2:0] Wpc;
  logic       Wir, Waluresult, mem_req, io_req, mem_we, reg_we, div_start, Wepc;
  logic [4:0] exc_code;
  logic [2:0] state;
  logic       busy;

  mc_control_seq #(.ADDR_HIGH_W(AW), .MEM_WAIT_MAX(15), .DIV_CYCLES(32)) dut (
    .clock(clock), .reset(reset),
    .is_jump(is_jump), .is_link(is_link), .is_eret(is_eret), .is_load(is_load),
    .is_store(is_store), .is_branch(is_branch), .is_div(is_div),
    .branch_taken(branch_taken), .ex_reserved(ex_reserved), .ex_syscall(ex_syscall),
    .ex_break(ex_break), .irq(irq), .addr_high(addr_high), .mem_ready(mem_ready),
    .Wpc(Wpc), .Wir(Wir), .Waluresult(Waluresult), .mem_req(mem_req), .io_req(io_req),
    .mem_we(mem_we), .reg_we(reg_we), .div_start(div_start), .Wepc(Wepc),
    .exc_code(exc_code), .state(state), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [19:0] act;
  assign act = {state, Wpc, Wir, Waluresult, mem_req, io_req, mem_we, reg_we,
                div_start, Wepc, exc_code, busy};

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [4:0]  cur_exc = 5'd0;

  function automatic logic [19:0] pack(input logic [2:0] st, input logic [2:0] wpc,
                                       input logic [7:0] strb, input logic [4:0] exc);
    return {st, wpc, strb, exc, (st != ST_IF)};
  endfunction

  // monitor / scoreboard
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      logic [19:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %h required %h (t=%0t)", n, act, e, $time);
      end
    end
  end

  // driver: queue this cycle's expected outputs, then advance to just after the next edge
  task automatic cyc(input logic [2:0] st, input logic [2:0] wpc, input logic [7:0] strb,
                     input string name);
    exp_q.push_back(pack(st, wpc, strb, cur_exc));
    name_q.push_back(name);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic clr_flags();
    is_jump = 0; is_link = 0; is_eret = 0; is_load = 0; is_store = 0;
    is_branch = 0; is_div = 0; branch_taken = 0;
    ex_reserved = 0; ex_syscall = 0; ex_break = 0; irq = 0;
    addr_high = '0; mem_ready = 0;
  endtask

  task automatic front(input string tag);
    cyc(ST_IF, 3'b001, S_IR, {tag, "_if"});
    cyc(ST_ID, 3'b000, 8'h00, {tag, "_id"});
  endtask

  initial begin
    @(posedge clock); #1;
    cyc(ST_INIT, 3'b000, 8'h00, "reset_hold");
    reset = 1'b0;
    cyc(ST_INIT, 3'b000, 8'h00, "init");

    // ALU op: 1,2,3,5
    front("alu");
    cyc(ST_EXE, 3'b000, S_ALU, "alu_exe");
    cyc(ST_WB, 3'b000, S_RWE, "alu_wb");

    // load from memory, ready after 3 wait cycles
    is_load = 1;
    front("ldm");
    cyc(ST_EXE, 3'b000, S_ALU, "ldm_exe");
    for (int i = 0; i < 3; i++) cyc(ST_MEM, 3'b000, S_MREQ, "ldm_wait");
    mem_ready = 1;
    cyc(ST_MEM, 3'b000, S_MREQ, "ldm_ready");
    mem_ready = 0;
    cyc(ST_WB, 3'b000, S_RWE, "ldm_wb");

    // load from IO space
    addr_high = '1;
    front("ldio");
    cyc(ST_EXE, 3'b000, S_ALU, "ldio_exe");
    cyc(ST_MEM, 3'b000, S_IOREQ, "ldio_mem");
    cyc(ST_WB, 3'b000, S_RWE, "ldio_wb");
    clr_flags();

    // store, mem_ready never: 15 MEM cycles, last drops mem_req, then bus error
    is_store = 1;
    front("stto");
    cyc(ST_EXE, 3'b000, S_ALU, "stto_exe");
    for (int i = 0; i < 14; i++) cyc(ST_MEM, 3'b000, S_MREQ | S_WE, "stto_wait");
    cyc(ST_MEM, 3'b000, 8'h00, "stto_last");
    cur_exc = 5'd7;
    cyc(ST_EXC, 3'b100, S_EPC, "stto_exc");
    clr_flags();

    // load, mem_ready arrives exactly in the timeout cycle: success
    is_load = 1;
    front("ldlate");
    cyc(ST_EXE, 3'b000, S_ALU, "ldlate_exe");
    for (int i = 0; i < 14; i++) cyc(ST_MEM, 3'b000, S_MREQ, "ldlate_wait");
    mem_ready = 1;
    cyc(ST_MEM, 3'b000, S_MREQ, "ldlate_ready");
    mem_ready = 0;
    cyc(ST_WB, 3'b000, S_RWE, "ldlate_wb");
    clr_flags();

    // store ready in first cycle with irq: interrupt entry after completion
    is_store = 1; mem_ready = 1; irq = 1;
    front("stirq");
    cyc(ST_EXE, 3'b000, S_ALU, "stirq_exe");
    cyc(ST_MEM, 3'b000, S_MREQ | S_WE, "stirq_mem");
    cur_exc = 5'd0;
    cyc(ST_EXC, 3'b100, S_EPC, "stirq_exc");
    clr_flags();

    // divide: 32 DIVW cycles
    is_div = 1;
    front("div");
    cyc(ST_EXE, 3'b000, S_ALU | S_DIV, "div_exe");
    for (int i = 0; i < 32; i++) cyc(ST_DIVW, 3'b000, 8'h00, "div_wait");
    cyc(ST_WB, 3'b000, S_RWE, "div_wb");
    clr_flags();

    // reserved + syscall (+ jump) in ID: reserved wins, code 10
    ex_reserved = 1; ex_syscall = 1; is_jump = 1;
    front("rsv");
    cur_exc = 5'd10;
    cyc(ST_EXC, 3'b100, S_EPC, "rsv_exc");
    clr_flags();

    // taken branch with irq
    is_branch = 1; branch_taken = 1; irq = 1;
    front("brirq");
    cyc(ST_EXE, 3'b011, S_ALU, "brirq_exe");
    cur_exc = 5'd0;
    cyc(ST_EXC, 3'b100, S_EPC, "brirq_exc");
    clr_flags();

    // syscall + break: code 8; break alone: code 9
    ex_syscall = 1; ex_break = 1;
    front("sys");
    cur_exc = 5'd8;
    cyc(ST_EXC, 3'b100, S_EPC, "sys_exc");
    clr_flags();
    ex_break = 1;
    front("brk");
    cur_exc = 5'd9;
    cyc(ST_EXC, 3'b100, S_EPC, "brk_exc");
    clr_flags();

    // jump-and-link, no irq
    is_jump = 1; is_link = 1;
    cyc(ST_IF, 3'b001, S_IR, "jal_if");
    cyc(ST_ID, 3'b010, S_RWE, "jal_id");
    // jump with irq: interrupt entry
    irq = 1; is_link = 0;
    cyc(ST_IF, 3'b001, S_IR, "jirq_if");
    cyc(ST_ID, 3'b010, 8'h00, "jirq_id");
    cur_exc = 5'd0;
    cyc(ST_EXC, 3'b100, S_EPC, "jirq_exc");
    clr_flags();

    // eret ignores irq
    is_eret = 1; irq = 1;
    cyc(ST_IF, 3'b001, S_IR, "eret_if");
    cyc(ST_ID, 3'b101, 8'h00, "eret_id");
    clr_flags();

    // not-taken branch
    is_branch = 1;
    front("brnt");
    cyc(ST_EXE, 3'b000, S_ALU, "brnt_exe");
    clr_flags();

    // ALU op with irq: entry after WB, after setting a nonzero code first
    ex_break = 1;
    front("brk2");
    cur_exc = 5'd9;
    cyc(ST_EXC, 3'b100, S_EPC, "brk2_exc");
    clr_flags();
    irq = 1;
    front("aluirq");
    cyc(ST_EXE, 3'b000, S_ALU, "aluirq_exe");
    cyc(ST_WB, 3'b000, S_RWE, "aluirq_wb");
    cur_exc = 5'd0;
    cyc(ST_EXC, 3'b100, S_EPC, "aluirq_exc");
    clr_flags();

    // async reset during DIVW (code 9 set first so reset clearing is visible)
    ex_break = 1;
    front("brk3");
    cur_exc = 5'd9;
    cyc(ST_EXC, 3'b100, S_EPC, "brk3_exc");
    clr_flags();
    is_div = 1;
    front("divrst");
    cyc(ST_EXE, 3'b000, S_ALU | S_DIV, "divrst_exe");
    for (int i = 0; i < 5; i++) cyc(ST_DIVW, 3'b000, 8'h00, "divrst_wait");
    #1;
    chk("divrst_pre", act, pack(ST_DIVW, 3'b000, 8'h00, 5'd9));
    reset = 1'b1;
    #1;
    cur_exc = 5'd0;
    chk("divrst_async", act, pack(ST_INIT, 3'b000, 8'h00, 5'd0));
    @(posedge clock); #1;
    reset = 1'b0;
    clr_flags();
    cyc(ST_INIT, 3'b000, 8'h00, "divrst_init");

    // async reset during MEM with mem_req high
    is_load = 1;
    front("memrst");
    cyc(ST_EXE, 3'b000, S_ALU, "memrst_exe");
    cyc(ST_MEM, 3'b000, S_MREQ, "memrst_wait");
    cyc(ST_MEM, 3'b000, S_MREQ, "memrst_wait");
    #1;
    chk("memrst_pre", act, pack(ST_MEM, 3'b000, S_MREQ, 5'd0));
    reset = 1'b1;
    #1;
    chk("memrst_async", act, pack(ST_INIT, 3'b000, 8'h00, 5'd0));
    @(posedge clock); #1;
    reset = 1'b0;
    clr_flags();
    cyc(ST_INIT, 3'b000, 8'h00, "memrst_init");

    // ordinary ALU op after recovery
    front("alu2");
    cyc(ST_EXE, 3'b000, S_ALU, "alu2_exe");
    cyc(ST_WB, 3'b000, S_RWE, "alu2_wb");
    cyc(ST_IF, 3'b001, S_IR, "alu2_ret");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_seq.md
# mc_control_seq

Parametrised multicycle control sequencer. Next-generation counterpart to the single-issue multicycle controller in the CPU core. It steps each instruction through fetch, decode, execute, memory and write-back states and drives the PC/IR/ALU-result write strobes. Over the current controller it adds:
- memory wait states with a ready handshake and a bus-error timeout
- a configurable multi-cycle divide stall
- exception and interrupt entry
- ERET return

Instruction decode stays outside the block; it consumes decoded class flags.

## Interface
Parameters:
- ADDR_HIGH_W, 22: width of the address high field compared for IO space (all ones = IO)
- MEM_WAIT_MAX, 15: maximum MEM cycles waiting for mem_ready before bus error (>=1)
- DIV_CYCLES, 32: divider stall length in cycles (>=1)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- is_jump, is_link, is_eret, is_load, is_store, is_branch, is_div  in  1 each  decoded instruction class (valid from ID onward)
- branch_taken  in  1  branch condition result, valid in EXE
- ex_reserved, ex_syscall, ex_break  in  1 each  decode exceptions, valid in ID
- irq  in  1  level interrupt request, already masked by status
- addr_high  in  ADDR_HIGH_W  ALU result high bits, valid in MEM
- mem_ready  in  1  memory access complete
- Wpc  out  3  PC source: 000 hold, 001 PC+4, 010 jump target, 011 branch target, 100 exception vector, 101 EPC
- Wir  out  1  load IR
- Waluresult  out  1  load ALU result register
- mem_req, io_req  out  1 each  memory / IO access request
- mem_we  out  1  write qualifier for mem_req/io_req (store)
- reg_we  out  1  register-file write strobe
- div_start  out  1  one-cycle divider start pulse
- Wepc  out  1  capture current PC into EPC
- exc_code  out  5  cause code, held until next exception
- state  out  3  current state encoding
- busy  out  1  high when state is not IF

## Operation
State encoding: INIT=0, IF=1, ID=2, EXE=3, MEM=4, WB=5, DIVW=6, EXC=7. Outputs are combinational from state plus inputs unless stated.

Transitions:
- INIT -> IF.
- IF: Wir=1, Wpc=001 -> ID.
- ID, first matching rule wins:
  - Any ex_* -> EXC. exc_code priority: reserved=10, syscall=8, break=9.
  - is_eret: Wpc=101 -> IF. irq is not checked.
  - is_jump: Wpc=010, reg_we=is_link -> IF, or EXC if irq.
  - Otherwise -> EXE.
- EXE: Waluresult=1.
  - is_load|is_store -> MEM.
  - is_branch: Wpc=011 if branch_taken -> IF, or EXC if irq.
  - is_div: div_start=1 -> DIVW.
  - Otherwise -> WB.
- MEM:
  - IO access (addr_high all ones): io_req=1, mem_we=is_store. Completes in one cycle.
  - Memory access: mem_req=1, mem_we=is_store. Held until mem_ready.
  - Wait counter increments each MEM cycle without mem_ready.
  - Completion: load -> WB; store -> IF, or EXC if irq.
  - Counter reaching MEM_WAIT_MAX without mem_ready: mem_req drops that cycle -> EXC, exc_code=7.
- DIVW: counter runs DIV_CYCLES cycles, then -> WB.
- WB: reg_we=1 -> IF, or EXC if irq.
- EXC: Wepc=1, Wpc=100 -> IF.
  - An interrupt entry sets exc_code=0.
  - The PC update from the completing state has already landed, so EPC holds the next instruction.

Counters and boundaries:
- Both counters clear on entering MEM or DIVW.
- The MEM counter is $clog2(MEM_WAIT_MAX+1) bits and saturates; it never wraps.
- irq is sampled only on instruction-completion transitions listed above. It is never sampled in IF, EXE-to-MEM, or DIVW.
- mem_ready arriving in the timeout cycle counts as success; no error.

## Timing
- Reset value of every output and register: state=INIT, all strobes 0, Wpc=000, exc_code=0, counters 0, busy=1 (state is not IF).
- Reset asserted mid-operation forces INIT immediately. Any pending request drops asynchronously.
- Latency in cycles, IF through return to IF:
  - jump / eret: 2
  - branch: 3
  - ALU op: 4
  - store with mem_ready in first cycle: 4
  - load: 5 + wait cycles
  - divide: 4 + DIV_CYCLES
- EXC adds one cycle.
- exc_code updates on the clock edge that enters EXC.

## Test plan
- Reset, then ALU op (no flags): states 1,2,3,5,1. Wir in IF, Waluresult in EXE, reg_we in WB, Wpc=001 only in IF.
- Load to memory, mem_ready after 3 wait cycles: mem_req high 4 cycles, mem_we=0, then WB with reg_we=1. Same with addr_high=all ones: io_req for 1 cycle, no mem_req.
- Store with mem_ready never asserted, MEM_WAIT_MAX=15: 15 MEM cycles, then EXC with Wepc=1, Wpc=100, exc_code=7.
- Divide, DIV_CYCLES=32: div_start for 1 cycle in EXE, exactly 32 DIVW cycles, then WB.
- Taken branch with irq high: Wpc=011 in EXE, next state EXC, exc_code=0. ID with ex_reserved and ex_syscall both high: exc_code=10.
- Reset asserted during DIVW and during MEM with mem_req high: state=0 and all strobes low without waiting for a clock edge.
